// File: rtl/sobel_stream.sv
// rtl/sobel_stream.sv - streaming 3x3 Sobel edge detector with internal line buffers
// Window built from two line buffers; |Gx|+|Gy| pipelined over four stages, then mode select.
module sobel_stream #(
  parameter int PIX_W  = 8,
  parameter int LINE_W = 640,
  parameter int CNT_W  = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               pix_valid,
  input  logic               frame_start,
  input  logic [PIX_W-1:0]   pix_in,
  input  logic [1:0]         mode,
  input  logic [PIX_W+2:0]   threshold,
  output logic               edge_valid,
  output logic [PIX_W-1:0]   edge_out,
  output logic [PIX_W-1:0]   mag_out
);

  localparam int SW  = PIX_W + 3;
  localparam int AW  = PIX_W + 2;
  localparam int AIW = $clog2(LINE_W);

  logic [PIX_W-1:0] lb1_mem [LINE_W];
  logic [PIX_W-1:0] lb2_mem [LINE_W];

  logic [CNT_W-1:0] col_q, row_q, col_d, row_d, cur_col, cur_row;
  logic [AIW-1:0]   lb_idx;
  logic [PIX_W-1:0] tap1, tap2;
  logic             border;

  logic [PIX_W-1:0] win_q [9];
  logic             border_q;
  logic             v0_q, v1_q, v2_q, v3_q;
  logic signed [SW-1:0] z [9];
  logic signed [SW-1:0] gx_d, gy_d, gx_q, gy_q;
  logic [AW-1:0]    ax_q, ay_q;
  logic [SW-1:0]    sum_q;
  logic [PIX_W-1:0] ctr1_q, ctr2_q, ctr3_q;
  logic [PIX_W-1:0] sat_sum;
  logic             is_edge;

  logic             edge_valid_q;
  logic [PIX_W-1:0] edge_out_q, mag_out_q;

  // frame_start overrides the running counters for the pixel that carries it
  always_comb begin
    cur_col = frame_start ? '0 : col_q;
    cur_row = frame_start ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    if (pix_valid) begin
      if (cur_col == CNT_W'(LINE_W - 1)) begin
        col_d = '0;
        row_d = (&cur_row) ? cur_row : cur_row + CNT_W'(1);
      end else begin
        col_d = cur_col + CNT_W'(1);
        row_d = cur_row;
      end
    end
  end

  assign lb_idx = cur_col[AIW-1:0];
  assign tap1   = lb1_mem[lb_idx];
  assign tap2   = lb2_mem[lb_idx];
  assign border = (cur_row < CNT_W'(2)) || (cur_col < CNT_W'(2));

  always_ff @(posedge clock) begin
    if (!reset && pix_valid) begin
      lb1_mem[lb_idx] <= pix_in;
      lb2_mem[lb_idx] <= tap1;
    end
  end

  always_comb begin
    for (int i = 0; i < 9; i++) z[i] = $signed({3'b000, win_q[i]});
    gx_d = (z[2] - z[0]) + ((z[5] - z[3]) <<< 1) + (z[8] - z[6]);
    gy_d = (z[0] - z[6]) + ((z[1] - z[7]) <<< 1) + (z[2] - z[8]);
  end

  assign sat_sum = (sum_q > SW'(2**PIX_W - 1)) ? '1 : sum_q[PIX_W-1:0];
  assign is_edge = sum_q > threshold;

  always_ff @(posedge clock) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
      border_q     <= 1'b0;
      v0_q         <= 1'b0;
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      v3_q         <= 1'b0;
      gx_q         <= '0;
      gy_q         <= '0;
      ax_q         <= '0;
      ay_q         <= '0;
      sum_q        <= '0;
      ctr1_q       <= '0;
      ctr2_q       <= '0;
      ctr3_q       <= '0;
      edge_valid_q <= 1'b0;
      edge_out_q   <= '0;
      mag_out_q    <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      if (pix_valid) begin
        win_q[0] <= win_q[1];
        win_q[1] <= win_q[2];
        win_q[2] <= tap2;
        win_q[3] <= win_q[4];
        win_q[4] <= win_q[5];
        win_q[5] <= tap1;
        win_q[6] <= win_q[7];
        win_q[7] <= win_q[8];
        win_q[8] <= pix_in;
        border_q <= border;
      end
      v0_q <= pix_valid;
      v1_q <= v0_q;
      v2_q <= v1_q;
      v3_q <= v2_q;
      // data stages run freely; only the valid bits decide what reaches the outputs
      gx_q   <= border_q ? '0 : gx_d;
      gy_q   <= border_q ? '0 : gy_d;
      ax_q   <= gx_q[SW-1] ? AW'(-gx_q) : AW'(gx_q);
      ay_q   <= gy_q[SW-1] ? AW'(-gy_q) : AW'(gy_q);
      sum_q  <= {1'b0, ax_q} + {1'b0, ay_q};
      ctr1_q <= win_q[4];
      ctr2_q <= ctr1_q;
      ctr3_q <= ctr2_q;
      edge_valid_q <= v3_q;
      if (v3_q) begin
        mag_out_q <= sat_sum;
        case (mode)
          2'd0:    edge_out_q <= is_edge ? '0 : '1;
          2'd1:    edge_out_q <= is_edge ? '1 : '0;
          2'd2:    edge_out_q <= sat_sum;
          default: edge_out_q <= ctr3_q;
        endcase
      end
    end
  end

  assign edge_valid = edge_valid_q;
  assign edge_out   = edge_out_q;
  assign mag_out    = mag_out_q;

endmodule
